// File: rtl/divider_unit.sv
// RV32M divide/remainder unit: radix-2 restoring division, one quotient bit per cycle.
// Latency: 33 cycles from the accepting edge to done (1 cycle for divide-by-zero / signed overflow).
// Backpressure: busy is high while an op is in flight; starts arriving while busy are dropped, not queued.
module divider_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        div_start,
   input  logic [2:0]  div_op,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic        busy,
   output logic        done,
   output logic [31:0] result
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DIVIDE = 2'd1,
      S_FINISH = 2'd2
   } state_t;

   state_t      state_q,    state_d;
   logic [5:0]  cnt_q,      cnt_d;
   logic [31:0] rem_q,      rem_d;
   logic [31:0] quo_q,      quo_d;
   logic [31:0] dvsr_q,     dvsr_d;
   logic [31:0] result_q,   result_d;
   logic        neg_quo_q,  neg_quo_d;
   logic        neg_rem_q,  neg_rem_d;
   logic        is_rem_q,   is_rem_d;
   logic        done_q,     done_d;

   // Decode of the incoming request. Bit 0 of the op selects unsigned,
   // bit 1 selects remainder, bit 2 marks the request as a divide at all.
   logic        req_signed;
   logic        req_accept;
   logic        req_div_zero;
   logic        req_overflow;
   logic [31:0] abs_dividend;
   logic [31:0] abs_divisor;

   assign req_signed   = ~div_op[0];
   assign req_accept   = div_start & div_op[2];
   assign req_div_zero = (divisor == 32'd0);
   assign req_overflow = req_signed
                         & (dividend == 32'h8000_0000)
                         & (divisor  == 32'hFFFF_FFFF);

   // Magnitudes for signed ops; -2^31 maps onto 0x80000000, which is the
   // correct unsigned magnitude, so no special handling is needed here.
   assign abs_dividend = (req_signed && dividend[31]) ? (32'd0 - dividend) : dividend;
   assign abs_divisor  = (req_signed && divisor[31])  ? (32'd0 - divisor)  : divisor;

   // One restoring step: shift {rem,quo} left by one and try to subtract
   // the divisor from the upper half. The 33-bit trial keeps the bit that
   // falls out of rem so the sign of the difference is exact.
   logic [31:0] rem_shift;
   logic [32:0] trial;
   logic        trial_ok;

   assign rem_shift = {rem_q[30:0], quo_q[31]};
   assign trial     = {rem_q[31], rem_shift} - {1'b0, dvsr_q};
   assign trial_ok  = ~trial[32];

   // Final sign fix-up. The stored flags are zero for unsigned ops and for
   // the preset special-case results, so the same path serves every case.
   logic [31:0] quo_signed;
   logic [31:0] rem_signed;

   assign quo_signed = neg_quo_q ? (32'd0 - quo_q) : quo_q;
   assign rem_signed = neg_rem_q ? (32'd0 - rem_q) : rem_q;

   // Next-state and datapath control for the IDLE -> DIVIDE -> FINISH sequence.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      dvsr_d    = dvsr_q;
      result_d  = result_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      is_rem_d  = is_rem_q;
      done_d    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (req_accept) begin
               is_rem_d = div_op[1];
               cnt_d    = 6'd0;
               dvsr_d   = abs_divisor;
               if (req_div_zero) begin
                  // Quotient of all ones, remainder is the raw dividend.
                  quo_d     = 32'hFFFF_FFFF;
                  rem_d     = dividend;
                  neg_quo_d = 1'b0;
                  neg_rem_d = 1'b0;
                  state_d   = S_FINISH;
               end else if (req_overflow) begin
                  // -2^31 / -1 wraps: quotient -2^31, remainder 0.
                  quo_d     = 32'h8000_0000;
                  rem_d     = 32'd0;
                  neg_quo_d = 1'b0;
                  neg_rem_d = 1'b0;
                  state_d   = S_FINISH;
               end else begin
                  // Dividend bits are shifted out of quo into rem while
                  // quotient bits are shifted in from the bottom.
                  quo_d     = abs_dividend;
                  rem_d     = 32'd0;
                  neg_quo_d = req_signed & (dividend[31] ^ divisor[31]);
                  neg_rem_d = req_signed & dividend[31];
                  state_d   = S_DIVIDE;
               end
            end
         end

         S_DIVIDE: begin
            if (trial_ok) begin
               rem_d = trial[31:0];
               quo_d = {quo_q[30:0], 1'b1};
            end else begin
               rem_d = rem_shift;
               quo_d = {quo_q[30:0], 1'b0};
            end
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'd31) begin
               state_d = S_FINISH;
            end
         end

         S_FINISH: begin
            result_d = is_rem_q ? rem_signed : quo_signed;
            done_d   = 1'b1;
            state_d  = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset; a reset mid-op
   // simply drops the in-flight division.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= 6'd0;
         rem_q     <= 32'd0;
         quo_q     <= 32'd0;
         dvsr_q    <= 32'd0;
         result_q  <= 32'd0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         is_rem_q  <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         dvsr_q    <= dvsr_d;
         result_q  <= result_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         is_rem_q  <= is_rem_d;
         done_q    <= done_d;
      end
   end

   // Busy covers every non-idle state, so it falls on the same edge that
   // registers done and rises on the edge that accepts a request.
   assign busy   = (state_q != S_IDLE);
   assign done   = done_q;
   assign result = result_q;

endmodule

// File: tb/tb_divider_unit.sv
// Self-checking bench for divider_unit: directed corner cases plus randomized ops.
// Expected results come from plain integer arithmetic following the RV32M rules.
// Latency, busy span, done pulse width and result hold are checked on every op.
module tb_divider_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        div_start;
   logic [2:0]  div_op;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   divider_unit dut (
      .clk       (clk),
      .rst       (rst),
      .div_start (div_start),
      .div_op    (div_op),
      .dividend  (dividend),
      .divisor   (divisor),
      .busy      (busy),
      .done      (done),
      .result    (result)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Reference: RV32M semantics with native integer division (truncating).
   function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
      int sa;
      int sb;
      sa = a;
      sb = b;
      if (b == 32'd0)
         return op[1] ? a : 32'hFFFF_FFFF;
      if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
         return op[1] ? 32'd0 : 32'h8000_0000;
      if (!op[0])
         return op[1] ? 32'(sa % sb) : 32'(sa / sb);
      return op[1] ? (a % b) : (a / b);
   endfunction

   function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
      if (b == 32'd0) return 1;
      if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
   endfunction

   // Issue one op (start is raised now, sampled at the next edge = E0), then
   // follow it to done. poke_at>0 raises a stray start sampled at E<poke_at>.
   // With chain=1 the task returns in the done cycle so the caller can start
   // the next op back-to-back.
   task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input bit chain,
                        input int poke_at);
      int lat;
      int busy_cnt;
      int exp_lat;
      exp_lat = ref_latency(op, a, b);
      div_start = 1'b1;
      div_op    = op;
      dividend  = a;
      divisor   = b;
      @(posedge clk); #1;
      div_start = 1'b0;
      div_op    = 3'($urandom);
      dividend  = $urandom;
      divisor   = $urandom;
      check({tag, "/busy_e0"}, {31'd0, busy}, 32'd1);
      check({tag, "/done_e0"}, {31'd0, done}, 32'd0);
      busy_cnt = 1;
      lat      = -1;
      for (int k = 1; k <= 40; k++) begin
         if (k == poke_at) begin
            div_start = 1'b1;
            div_op    = 3'b101;
            dividend  = $urandom;
            divisor   = $urandom_range(1, 9);
         end
         @(posedge clk); #1;
         div_start = 1'b0;
         if (done) begin
            lat = k;
            break;
         end
         if (busy) busy_cnt++;
      end
      check({tag, "/latency"}, 32'(lat), 32'(exp_lat));
      check({tag, "/result"}, result, exp);
      check({tag, "/busy_span"}, 32'(busy_cnt), 32'(exp_lat));
      check({tag, "/busy_at_done"}, {31'd0, busy}, 32'd0);
      if (!chain) begin
         @(posedge clk); #1;
         check({tag, "/done_pulse"}, {31'd0, done}, 32'd0);
         check({tag, "/hold"}, result, exp);
      end
   endtask

   initial begin
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      int          n_done;

      rst       = 1'b1;
      div_start = 1'b0;
      div_op    = 3'b000;
      dividend  = 32'd0;
      divisor   = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      check("reset/busy",   {31'd0, busy}, 32'd0);
      check("reset/done",   {31'd0, done}, 32'd0);
      check("reset/result", result, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Unsigned and signed basics.
      do_op("divu_100_7", 3'b101, 32'd100, 32'd7, 32'd14, 1'b0, 0);
      do_op("remu_100_7", 3'b111, 32'd100, 32'd7, 32'd2,  1'b0, 0);
      do_op("div_m7_2",   3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 0);
      do_op("rem_m7_2",   3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 0);
      do_op("div_7_m2",   3'b100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 0);
      do_op("rem_7_m2",   3'b110, 32'd7, 32'hFFFF_FFFE, 32'd1, 1'b0, 0);

      // Special cases finish one cycle after accept.
      do_op("div_by0",    3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0, 0);
      do_op("remu_by0",   3'b111, 32'h1234, 32'd0, 32'h1234, 1'b0, 0);
      do_op("div_ovf",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 0);
      do_op("rem_ovf",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 0);

      // Stray start at E5 while busy must be dropped.
      do_op("divu_poke",  3'b101, 32'd1000, 32'd3, 32'd333, 1'b0, 5);
      n_done = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done) n_done++;
      end
      check("poke/no_extra_done", 32'(n_done), 32'd0);

      // Non-divide op code is ignored in IDLE.
      div_start = 1'b1;
      div_op    = 3'b011;
      dividend  = 32'd10;
      divisor   = 32'd2;
      @(posedge clk); #1;
      div_start = 1'b0;
      check("ignored_op/busy", {31'd0, busy}, 32'd0);
      n_done = 0;
      repeat (5) begin
         @(posedge clk); #1;
         if (done) n_done++;
      end
      check("ignored_op/no_done", 32'(n_done), 32'd0);
      check("ignored_op/result_kept", result, 32'd333);

      // Reset asserted at E10 of a signed divide.
      div_start = 1'b1;
      div_op    = 3'b100;
      dividend  = 32'hFFFF_FF9C;
      divisor   = 32'd7;
      @(posedge clk); #1;
      div_start = 1'b0;
      repeat (9) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midreset/busy",   {31'd0, busy}, 32'd0);
      check("midreset/done",   {31'd0, done}, 32'd0);
      check("midreset/result", result, 32'd0);
      n_done = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done) n_done++;
      end
      check("midreset/no_done", 32'(n_done), 32'd0);

      // Back-to-back: next start raised in the done cycle.
      do_op("b2b_a", 3'b101, 32'd50, 32'd5, 32'd10, 1'b1, 0);
      do_op("b2b_b", 3'b110, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 1'b1, 0);
      do_op("b2b_c", 3'b111, 32'd77, 32'd0, 32'd77, 1'b1, 0);
      do_op("b2b_d", 3'b100, 32'd77, 32'd0, 32'hFFFF_FFFF, 1'b0, 0);

      // Randomized ops against the arithmetic reference.
      for (int i = 0; i < 60; i++) begin
         op = 3'b100 | 3'($urandom_range(0, 3));
         a  = $urandom;
         case ($urandom_range(0, 5))
            0:       b = 32'd0;
            1:       b = $urandom_range(1, 15);
            2:       b = 32'hFFFF_FFFF - $urandom_range(0, 15);
            3: begin
               a = 32'h8000_0000;
               b = 32'hFFFF_FFFF;
            end
            4:       b = $urandom >> $urandom_range(0, 31);
            default: b = $urandom;
         endcase
         do_op($sformatf("rand%0d", i), op, a, b, ref_result(op, a, b),
               1'($urandom_range(0, 1)), 0);
      end
      @(posedge clk); #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
